// File: rtl/axis_pair_subtractor.sv
// axis_pair_subtractor: two-stage AXI-Stream pipeline that emits the signed
// difference data_0 - data_1 of each joined pair and flags block boundaries.
module axis_pair_subtractor #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BLOCK_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data_0,
    input  logic [DATA_WIDTH-1:0] input_data_1,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [DATA_WIDTH:0]   output_data,
    output logic                  output_last
);

    localparam int unsigned RES_W = DATA_WIDTH + 1;
    localparam int unsigned CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SIZE - 1);

    // Stage 1 holding registers
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_s1_last;

    // Stage 2 (output) registers
    logic                  r_out_valid;
    logic [RES_W-1:0]      r_out_data;
    logic                  r_out_last;

    // Position of the next accepted pair within its block
    logic [CNT_W-1:0]      r_count;

    logic                  w_s2_free;
    logic                  w_s1_free;
    logic                  w_accept;
    logic                  w_count_wrap;
    logic [RES_W-1:0]      w_diff;

    // Handshake / advance conditions; ready reaches upstream through one gate
    assign w_s2_free    = !r_out_valid || output_ready;
    assign w_s1_free    = !r_s1_valid || w_s2_free;
    assign input_ready  = w_s1_free && !rst;
    assign w_accept     = input_valid && input_ready;
    assign w_count_wrap = (r_count == CNT_LAST);

    // Zero-extended subtraction; W+1 bits hold every possible result exactly
    assign w_diff = RES_W'(r_a) - RES_W'(r_b);

    assign output_valid = r_out_valid;
    assign output_data  = r_out_data;
    assign output_last  = r_out_last;

    // Block counter: advances only on accepted pairs, wraps at BLOCK_SIZE-1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_accept) begin
            if (w_count_wrap) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Stage 1: capture accepted pair, empty when it moves on with no refill
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_s1_last  <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_a        <= input_data_0;
            r_b        <= input_data_1;
            r_s1_last  <= w_count_wrap;
        end else if (w_s2_free) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: load the difference whenever the output slot frees up
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_diff;
                r_out_last <= r_s1_last;
            end
        end
    end

endmodule
